// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with trap entry/return and 64-bit counters
module csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        illegal_o,
  input  logic        exc_valid_i,
  input  logic [30:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic [31:0] cur_pc_i,
  input  logic        mret_i,
  input  logic        retire_i,
  output logic [1:0]  trap_mode_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam logic [1:0] TRAP_NONE   = 2'd0;
  localparam logic [1:0] TRAP_ENTER  = 2'd1;
  localparam logic [1:0] TRAP_RETURN = 2'd2;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // Only the architecturally meaningful bits of mstatus/mie/mip are stored.
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        mtie_q, mtie_d;
  logic        meie_q, meie_d;
  logic        mtip_q, mtip_d;
  logic        meip_q, meip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] mstatus_val, mie_val, mip_val;
  logic [31:0] old_val, new_val;
  logic        implemented, read_only;
  logic        is_write_op, illegal, csr_we;
  logic        pending, trap_enter, do_mret, do_write;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mie_val     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
  assign mip_val     = {20'b0, meip_q, 3'b0, mtip_q, 7'b0};

  // Address decode: current value, whether the CSR exists and whether it is read-only
  always_comb begin
    old_val     = 32'h0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr_i)
      12'h300: old_val = mstatus_val;
      12'h301: begin old_val = 32'h4000_0100;     read_only = 1'b1; end
      12'h304: old_val = mie_val;
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'h344: begin old_val = mip_val;           read_only = 1'b1; end
      12'hB00: old_val = mcycle_q[31:0];
      12'hB80: old_val = mcycle_q[63:32];
      12'hB02: old_val = minstret_q[31:0];
      12'hB82: old_val = minstret_q[63:32];
      12'hC00: begin old_val = mcycle_q[31:0];    read_only = 1'b1; end
      12'hC80: begin old_val = mcycle_q[63:32];   read_only = 1'b1; end
      12'hC02: begin old_val = minstret_q[31:0];  read_only = 1'b1; end
      12'hC82: begin old_val = minstret_q[63:32]; read_only = 1'b1; end
      12'hF14: begin old_val = HART_ID;           read_only = 1'b1; end
      default: implemented = 1'b0;
    endcase
  end

  // Operand merge and legality; a set/clear with a zero mask is a pure read
  always_comb begin
    new_val = csr_wdata_i;
    case (csr_op_i)
      OP_RS:   new_val = old_val | csr_wdata_i;
      OP_RC:   new_val = old_val & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
    is_write_op = (csr_op_i == OP_RW) ||
                  (((csr_op_i == OP_RS) || (csr_op_i == OP_RC)) && (csr_wdata_i != 32'h0));
    illegal     = csr_en_i && (!implemented || (is_write_op && read_only));
    csr_we      = csr_en_i && is_write_op && !illegal;
  end

  // Event arbitration: exception > interrupt > mret > CSR write
  always_comb begin
    pending    = mie_q && ((mtip_q && mtie_q) || (meip_q && meie_q));
    trap_enter = exc_valid_i || pending;
    do_mret    = mret_i && !trap_enter;
    do_write   = csr_we && !trap_enter && !mret_i;
  end

  // Combinational outputs; reset forces a quiet interface
  always_comb begin
    csr_rdata_o = (csr_en_i && !illegal) ? old_val : 32'h0;
    illegal_o   = illegal && !rst_i;
    if (rst_i)           trap_mode_o = TRAP_NONE;
    else if (trap_enter) trap_mode_o = TRAP_ENTER;
    else if (mret_i)     trap_mode_o = TRAP_RETURN;
    else                 trap_mode_o = TRAP_NONE;
    mtvec_o = mtvec_q;
    mepc_o  = mepc_q;
  end

  // Next-state: counters tick by default, then the winning event overrides
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtip_d     = irq_timer_i;
    meip_d     = irq_ext_i;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = (retire_i && !trap_enter) ? minstret_q + 64'd1 : minstret_q;

    if (trap_enter) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
      if (exc_valid_i) begin
        mepc_d   = {exc_pc_i[31:2], 2'b00};
        mcause_d = {1'b0, exc_cause_i};
        mtval_d  = exc_tval_i;
      end else begin
        mepc_d   = {cur_pc_i[31:2], 2'b00};
        mtval_d  = 32'h0;
        mcause_d = (meip_q && meie_q) ? 32'h8000_000B : 32'h8000_0007;
      end
    end else if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (do_write) begin
      case (csr_addr_i)
        12'h300: begin mie_d = new_val[3]; mpie_d = new_val[7]; end
        12'h304: begin mtie_d = new_val[7]; meie_d = new_val[11]; end
        12'h305: mtvec_d    = new_val;
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d     = {new_val[31:2], 2'b00};
        12'h342: mcause_d   = new_val;
        12'h343: mtval_d    = new_val;
        12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
        12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], new_val};
        12'hB82: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
      mtip_q     <= mtip_d;
      meip_q     <= meip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - scoreboard bench for csr_unit
module tb_csr_unit;

  localparam logic [1:0] TN = 2'd0;
  localparam logic [1:0] TE = 2'd1;
  localparam logic [1:0] TR = 2'd2;
  localparam int S_RDATA = 0, S_ILL = 1, S_TRAP = 2, S_MTVEC = 3, S_MEPC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        irq_timer;
  logic        irq_ext;
  logic [31:0] cur_pc;
  logic        mret;
  logic        retire;
  logic [1:0]  trap_mode;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  csr_unit #(.MTVEC_RST(32'h0000_1000), .HART_ID(32'h5)) dut (
    .clk_i(clk), .rst_i(rst),
    .csr_en_i(csr_en), .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .illegal_o(illegal),
    .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
    .irq_timer_i(irq_timer), .irq_ext_i(irq_ext), .cur_pc_i(cur_pc),
    .mret_i(mret), .retire_i(retire),
    .trap_mode_o(trap_mode), .mtvec_o(mtvec), .mepc_o(mepc)
  );

  task automatic expect_v(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle();
    csr_en = 0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
    exc_valid = 0; exc_cause = 31'h0; exc_pc = 32'h0; exc_tval = 32'h0;
    irq_timer = 0; irq_ext = 0; cur_pc = 32'h0; mret = 0; retire = 0;
  endtask

  // Advance to the next cycle and present a CSR access (op 00 with en 0 is idle)
  task automatic cyc(input logic en, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wd);
    @(posedge clk);
    #1;
    idle();
    csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
  endtask

  // Read via set with a zero mask and check the returned value
  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
    cyc(1'b1, 2'b10, addr, 32'h0);
    expect_v(S_RDATA, exp, name);
    expect_v(S_ILL, 32'h0, {name, "_ill"});
  endtask

  // Monitor: compares every queued expectation against the DUT outputs on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sel)
          S_RDATA: act = csr_rdata;
          S_ILL:   act = {31'h0, illegal};
          S_TRAP:  act = {30'h0, trap_mode};
          S_MTVEC: act = mtvec;
          default: act = mepc;
        endcase
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    csr_en = 1; csr_op = 2'b01; csr_addr = 12'h7C0; exc_valid = 1;
    expect_v(S_TRAP, {30'h0, TN}, "rst_trap");
    expect_v(S_ILL, 32'h0, "rst_ill");
    expect_v(S_MTVEC, 32'h0000_1000, "rst_mtvec");
    expect_v(S_MEPC, 32'h0, "rst_mepc");
    @(posedge clk); #1; idle(); rst = 1'b0;

    rd(12'h301, 32'h4000_0100, "misa");
    rd(12'h305, 32'h0000_1000, "mtvec_rst");
    rd(12'hF14, 32'h5, "mhartid");
    rd(12'h300, 32'h0000_1800, "mstatus_rst");

    cyc(1, 2'b01, 12'h305, 32'h100);
    expect_v(S_RDATA, 32'h1000, "csrrw_mtvec");
    cyc(1, 2'b10, 12'h305, 32'h3);
    expect_v(S_RDATA, 32'h100, "csrrs_mtvec");
    expect_v(S_ILL, 32'h0, "csrrs_mtvec_ill");
    expect_v(S_MTVEC, 32'h100, "mtvec_o_pre");
    cyc(0, 2'b00, 12'h0, 32'h0);
    expect_v(S_MTVEC, 32'h103, "mtvec_o_post");

    cyc(1, 2'b01, 12'hF14, 32'h1);
    expect_v(S_ILL, 32'h1, "mhartid_wr_ill");
    expect_v(S_RDATA, 32'h0, "mhartid_wr_rdata");
    rd(12'hF14, 32'h5, "mhartid_after");
    cyc(1, 2'b01, 12'hC00, 32'h1);
    expect_v(S_ILL, 32'h1, "cycle_wr_ill");
    cyc(1, 2'b01, 12'h7C0, 32'h1);
    expect_v(S_ILL, 32'h1, "unimpl_ill");
    expect_v(S_RDATA, 32'h0, "unimpl_rdata");
    rd(12'h301, 32'h4000_0100, "misa_rs0_legal");

    cyc(1, 2'b01, 12'h340, 32'h0000_A5A5);
    expect_v(S_RDATA, 32'h0, "mscratch_rw");
    cyc(1, 2'b11, 12'h340, 32'h0000_00A0);
    expect_v(S_RDATA, 32'h0000_A5A5, "mscratch_rc");
    rd(12'h340, 32'h0000_A505, "mscratch_after_rc");

    cyc(1, 2'b01, 12'h341, 32'h1237);
    rd(12'h341, 32'h1234, "mepc_align");
    expect_v(S_MEPC, 32'h1234, "mepc_o_align");

    // Exception with a simultaneous mscratch write that must be dropped
    cyc(1, 2'b10, 12'h300, 32'h8);
    expect_v(S_RDATA, 32'h1800, "set_mie");
    cyc(1, 2'b01, 12'h340, 32'hFFFF);
    exc_valid = 1; exc_cause = 31'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
    expect_v(S_TRAP, {30'h0, TE}, "exc_trap_mode");
    expect_v(S_RDATA, 32'h0000_A505, "exc_csr_rdata");
    rd(12'h342, 32'h2, "exc_mcause");
    expect_v(S_MEPC, 32'h80, "exc_mepc_o");
    rd(12'h343, 32'hDEAD, "exc_mtval");
    rd(12'h300, 32'h1880, "exc_mstatus");
    rd(12'h340, 32'h0000_A505, "exc_mscratch_kept");

    cyc(0, 2'b00, 12'h0, 32'h0);
    mret = 1;
    expect_v(S_TRAP, {30'h0, TR}, "mret_trap_mode");
    rd(12'h300, 32'h1888, "mret_mstatus");

    // Timer interrupt: mip is registered, so entry shows one cycle after the pulse
    cyc(1, 2'b01, 12'h304, 32'h80);
    expect_v(S_RDATA, 32'h0, "mie_wr");
    cyc(0, 2'b00, 12'h0, 32'h0);
    irq_timer = 1; cur_pc = 32'h200;
    expect_v(S_TRAP, {30'h0, TN}, "irq_latency");
    cyc(0, 2'b00, 12'h0, 32'h0);
    cur_pc = 32'h204;
    expect_v(S_TRAP, {30'h0, TE}, "irq_enter");
    rd(12'h342, 32'h8000_0007, "irq_mcause");
    expect_v(S_MEPC, 32'h204, "irq_mepc_o");
    expect_v(S_TRAP, {30'h0, TN}, "irq_done");
    rd(12'h343, 32'h0, "irq_mtval");
    rd(12'h300, 32'h1880, "irq_mstatus");
    cyc(0, 2'b00, 12'h0, 32'h0);
    mret = 1;
    rd(12'h300, 32'h1888, "irq_mret_mstatus");

    // mcycle carry into the high half
    cyc(1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
    cyc(1, 2'b01, 12'hB80, 32'h0);
    cyc(0, 2'b00, 12'h0, 32'h0);
    rd(12'hB80, 32'h1, "mcycleh_carry");
    rd(12'hB00, 32'h1, "mcycle_low");
    rd(12'hC80, 32'h1, "cycleh_ro_read");

    // 64-bit wrap
    cyc(1, 2'b01, 12'hB80, 32'hFFFF_FFFF);
    cyc(1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
    cyc(0, 2'b00, 12'h0, 32'h0);
    rd(12'hB80, 32'h0, "mcycle_wrap");

    // minstret: counts retires, not during trap entry
    cyc(1, 2'b01, 12'hB02, 32'd10);
    rd(12'hB02, 32'd10, "minstret_w");
    retire = 1;
    rd(12'hB02, 32'd11, "minstret_inc");
    retire = 1;
    rd(12'hB02, 32'd12, "minstret_inc2");
    retire = 1; exc_valid = 1; exc_cause = 31'd3;
    rd(12'hC02, 32'd12, "instret_trap_hold");

    // Reset during a trap and a write discards both
    cyc(1, 2'b01, 12'h340, 32'h1234);
    exc_valid = 1; rst = 1;
    expect_v(S_TRAP, {30'h0, TN}, "rst_mid_trap");
    expect_v(S_ILL, 32'h0, "rst_mid_ill");
    @(posedge clk); #1; idle(); rst = 0;
    rd(12'h340, 32'h0, "rst_mscratch");
    expect_v(S_MTVEC, 32'h1000, "rst_mtvec_o");
    expect_v(S_MEPC, 32'h0, "rst_mepc_o");
    rd(12'h300, 32'h1800, "rst_mstatus");

    cyc(0, 2'b00, 12'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 The block SHALL have parameter MTVEC_RST, default 32'h0000_0000, giving the mtvec reset value.
REQ-002 The block SHALL have parameter HART_ID, default 32'h0, giving the mhartid read value.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port csr_en_i, input, 1 bit: a CSR instruction is valid this cycle.
REQ-006 Port csr_op_i, input, 2 bits: 01 RW, 10 RS (set), 11 RC (clear), 00 none.
REQ-007 Port csr_addr_i, input, 12 bits: CSR address.
REQ-008 Port csr_wdata_i, input, 32 bits: write/mask operand.
REQ-009 Port csr_rdata_o, output, 32 bits: old CSR value.
REQ-010 Port illegal_o, output, 1 bit: the CSR access is illegal.
REQ-011 Ports exc_valid_i, input, 1 bit; exc_cause_i, input, 31 bits; exc_pc_i, input, 32 bits; exc_tval_i, input, 32 bits: synchronous exception request.
REQ-012 Ports irq_timer_i and irq_ext_i, input, 1 bit each: level-sensitive interrupt lines.
REQ-013 Port cur_pc_i, input, 32 bits: PC recorded as mepc when an interrupt is taken.
REQ-014 Port mret_i, input, 1 bit: an MRET is valid this cycle.
REQ-015 Port retire_i, input, 1 bit: an instruction retires this cycle.
REQ-016 Port trap_mode_o, output, trap-mode enum width: TRAP_NONE, TRAP_ENTER or TRAP_RETURN, driven to the trap redirect stage.
REQ-017 Ports mtvec_o and mepc_o, output, 32 bits each: current mtvec and mepc register values.

Function
REQ-018 The block SHALL implement the following CSRs:
- mstatus (0x300): MIE is bit 3, MPIE is bit 7, MPP[12:11] reads 2'b11, all other bits read 0.
- misa (0x301): reads 32'h4000_0100.
- mie (0x304): MTIE is bit 7, MEIE is bit 11.
- mtvec (0x305).
- mscratch (0x340).
- mepc (0x341): bits [1:0] are forced to 0.
- mcause (0x342) and mtval (0x343).
- mip (0x344): MTIP is bit 7, MEIP is bit 11.
- mcycle/mcycleh (0xB00/0xB80) and minstret/minstreth (0xB02/0xB82).
- cycle/cycleh/instret/instreth (0xC00/0xC80/0xC02/0xC82).
- mhartid (0xF14).
REQ-019 csr_rdata_o SHALL be combinational and SHALL show the pre-edge value of the addressed CSR; it SHALL be 0 when csr_en_i=0 or the access is illegal.
REQ-020 The new value SHALL be: RW -> wdata; RS -> old | wdata; RC -> old & ~wdata.
REQ-021 An RS or RC with wdata=0 SHALL NOT count as a write.
REQ-022 illegal_o SHALL be high when csr_en_i=1 and the address is unimplemented, or when a write targets a read-only CSR (misa, mip, 0xCxx, mhartid).
REQ-023 An illegal access SHALL change no state.
REQ-024 mip SHALL be registered: it captures irq_timer_i and irq_ext_i each cycle, giving one cycle of latency.
REQ-025 The interrupt condition SHALL be pending = mstatus.MIE & |(mip & mie).
REQ-026 Event priority SHALL be exception > interrupt > mret > CSR write.
REQ-027 Only the highest-priority event SHALL take effect in a cycle; lower-priority CSR writes are suppressed.
REQ-028 trap_mode_o SHALL be combinational:
- TRAP_ENTER on exc_valid_i or pending;
- TRAP_RETURN on mret_i;
- TRAP_NONE otherwise.
REQ-029 On trap entry the block SHALL, at the next edge:
- set MPIE to MIE and MIE to 0;
- on an exception, set mepc to exc_pc_i, mcause to {1'b0, exc_cause_i} and mtval to exc_tval_i;
- on an interrupt, set mepc to cur_pc_i, mtval to 0, and mcause to 32'h8000_000B if MEIP&MEIE, else 32'h8000_0007.
REQ-030 On mret the block SHALL set MIE to MPIE and MPIE to 1.
REQ-031 The 64-bit mcycle SHALL increment every cycle, carrying from the low half into the high half.
REQ-032 The 64-bit minstret SHALL increment when retire_i=1 and no trap entry occurs in that cycle.
REQ-033 A CSR write to either half of a counter SHALL override that counter's increment in that cycle; the other half holds.
REQ-034 Counter overflow at 64'hFFFF_FFFF_FFFF_FFFF SHALL wrap to 0.
REQ-035 mtvec_o and mepc_o SHALL reflect the registered values, so an update is visible the cycle after the edge.

Reset
REQ-036 While rst_i=1 all registers SHALL clear asynchronously, with these exceptions: mtvec resets to MTVEC_RST, and MPP reads 2'b11.
REQ-037 A reset asserted mid-trap or mid-write SHALL discard that event.
REQ-038 During reset, outputs SHALL be trap_mode_o=TRAP_NONE and illegal_o=0.

Verification
REQ-039 CSRRW 0x305 wdata 32'h0000_0100, then CSRRS 0x305 wdata 32'h3 -> rdata 0x100 on the second access; mtvec_o 0x103; illegal_o 0.
REQ-040 exc_valid_i with cause 2, pc 0x80, tval 0xDEAD, MIE=1 -> trap_mode_o=TRAP_ENTER; next cycle mepc_o 0x80, mcause 2, mtval 0xDEAD, MIE 0, MPIE 1.
REQ-041 mie=0x80, MIE=1, irq_timer_i pulsed high -> TRAP_ENTER one cycle after assertion; mcause 0x8000_0007; mepc equals cur_pc_i.
REQ-042 mret_i with MPIE=1 -> TRAP_RETURN; MIE 1 next cycle.
REQ-043 exc_valid_i and a CSRRW to mscratch in the same cycle -> mscratch unchanged.
REQ-044 Write mcycle=32'hFFFF_FFFF and mcycleh=0 -> after 2 cycles mcycleh reads 1.
REQ-045 CSRRW to 0xF14 -> illegal_o 1, no state change.
